esc_pwm_generator: RTL



---
 rtl/esc_pwm_pkg.sv | 18 +
 rtl/pwm_timebase.sv | 44 ++++
 rtl/esc_pwm_generator.sv | 103 ++++++++++
 3 files changed

// File: rtl/esc_pwm_pkg.sv
// Shared constants, FSM state encoding and duty clamp helper for the ESC PWM generator.
package esc_pwm_pkg;

    localparam logic [7:0] DUTY_MAX  = 8'h64;
    localparam logic [7:0] DUTY_IDLE = 8'h32;
    localparam logic [6:0] PCT_LAST  = 7'd99;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMING   = 2'd1,
        ARMED    = 2'd2
    } esc_state_t;

    function automatic logic [7:0] clamp_duty(input logic [7:0] duty);
        return (duty > DUTY_MAX) ? DUTY_MAX : duty;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Step/percent timebase: period_start pulses with the counters at zero, period_last marks the final cycle.
// The first cycle after reset holds the counters at zero so that cycle is the first period start.
module pwm_timebase
    import esc_pwm_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [6:0] pct_cnt,
    output logic       period_start,
    output logic       period_last
);

    localparam int unsigned STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    logic [STEP_W-1:0] step_cnt;
    logic              running;
    logic              step_wrap;

    assign step_wrap   = (step_cnt == STEP_W'(STEP_CYCLES - 1));
    assign period_last = running && step_wrap && (pct_cnt == PCT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running      <= 1'b0;
            step_cnt     <= '0;
            pct_cnt      <= '0;
            period_start <= 1'b0;
        end else if (!running) begin
            running      <= 1'b1;
            period_start <= 1'b1;
        end else begin
            period_start <= period_last;
            if (step_wrap) begin
                step_cnt <= '0;
                pct_cnt  <= (pct_cnt == PCT_LAST) ? '0 : pct_cnt + 7'd1;
            end else begin
                step_cnt <= step_cnt + STEP_W'(1);
            end
        end
    end

endmodule

// File: rtl/esc_pwm_generator.sv
// ESC PWM generator: arming FSM, period-boundary shadow duty with clamp, registered comparator output.
// Optional per-period slew limiting is compiled in with ESC_PWM_SLEW_LIMIT_EN.
module esc_pwm_generator
    import esc_pwm_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 500,
    parameter int unsigned ARM_PERIODS = 50,
    parameter int          MAX_SLEW    = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       arm,
    input  logic [7:0] duty_in,
    output logic       pwm_out,
    output logic       armed,
    output logic       period_start,
    output logic       clamped
);

    localparam int unsigned ACNT_W = (ARM_PERIODS > 0) ? $clog2(ARM_PERIODS + 1) : 1;

`ifdef ESC_PWM_SLEW_LIMIT_EN
    localparam int SLEW_STEP = (MAX_SLEW > 100) ? 100 : MAX_SLEW;
`else
    // Any step of 100 or more never limits, so live commands pass straight through.
    localparam int SLEW_STEP = 100 + MAX_SLEW;
`endif

    esc_state_t        state;
    logic [ACNT_W-1:0] arm_cnt;
    logic [7:0]        duty_active;
    logic [7:0]        target;
    logic [7:0]        next_live;
    logic [6:0]        pct_cnt;
    logic              period_last;

    pwm_timebase #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_timebase (
        .clk         (clk),
        .reset_n     (reset_n),
        .pct_cnt     (pct_cnt),
        .period_start(period_start),
        .period_last (period_last)
    );

    always_comb begin
        target    = clamp_duty(duty_in);
        next_live = target;
        if (target > duty_active) begin
            if (int'(target - duty_active) > SLEW_STEP)
                next_live = duty_active + 8'(SLEW_STEP);
        end else if (int'(duty_active - target) > SLEW_STEP) begin
            next_live = duty_active - 8'(SLEW_STEP);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= DISARMED;
            arm_cnt     <= '0;
            duty_active <= '0;
            armed       <= 1'b0;
            clamped     <= 1'b0;
            pwm_out     <= 1'b0;
        end else begin
            pwm_out <= ({1'b0, pct_cnt} < duty_active);
            // Disarm is immediate and takes priority over any boundary update.
            if (state != DISARMED && !arm) begin
                state       <= DISARMED;
                arm_cnt     <= '0;
                duty_active <= '0;
                armed       <= 1'b0;
                clamped     <= 1'b0;
            end else if (period_last) begin
                unique case (state)
                    DISARMED: begin
                        if (arm) begin
                            state       <= ARMING;
                            arm_cnt     <= '0;
                            duty_active <= DUTY_IDLE;
                        end
                    end
                    ARMING: begin
                        arm_cnt <= arm_cnt + 1'b1;
                        if (arm_cnt == ACNT_W'(ARM_PERIODS - 1)) begin
                            state       <= ARMED;
                            armed       <= 1'b1;
                            duty_active <= next_live;
                            clamped     <= (duty_in > DUTY_MAX);
                        end
                    end
                    ARMED: begin
                        duty_active <= next_live;
                        clamped     <= (duty_in > DUTY_MAX);
                    end
                    default: state <= DISARMED;
                endcase
            end
        end
    end

endmodule
